// File: rtl/jogo_pkg.sv
// Shared constants for the memory game: state codes decoded by the control
// unit through db_estado, ROM geometry, and elaboration-time helpers.
package jogo_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    BUSCA   = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    FIM     = 3'd4
  } estado_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0..m-1, never less than one.
  function automatic int largura(input int m);
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear and count enable.
module contador_m #(
  parameter int M = 16,
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         zera_s,
  input  logic         conta,
  output logic [N-1:0] q
);

  localparam logic [N-1:0] ULTIMO = N'(M - 1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (zera_s) begin
      q <= '0;
    end else if (conta) begin
      if (q == ULTIMO) q <= '0;
      else             q <= q + N'(1);
    end
  end

endmodule

// File: rtl/mostra_sequencia.sv
// Sequence presenter: walks ROM addresses 0..rodada, lighting each entry for
// T_ON cycles followed by T_OFF dark cycles, then pulses pronto for one cycle.
//
// Handshake with the control unit: iniciar is a request sampled only while
// idle (ocupado low); once accepted, ocupado stays high until the cycle after
// the single-cycle pronto. zera aborts at any time without a pronto.
module mostra_sequencia
  import jogo_pkg::*;
#(
  parameter int T_ON  = 50_000_000,
  parameter int T_OFF = 25_000_000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              zera,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] rodada,
  input  logic [DATA_W-1:0] rom_dado,
  output logic [ADDR_W-1:0] rom_endereco,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [2:0]        db_estado
);

  localparam int TMOD = max_int(T_ON, T_OFF);
  localparam int TW   = largura(TMOD);
  localparam logic [TW-1:0] FIM_ON  = TW'(T_ON - 1);
  localparam logic [TW-1:0] FIM_OFF = TW'(T_OFF - 1);

  estado_t           estado, estado_prox;
  logic [ADDR_W-1:0] rodada_reg;
  logic [TW-1:0]     timer;
  logic              zera_s, conta;
  logic              fim_on, fim_off, ultimo;

  assign fim_on  = (timer == FIM_ON);
  assign fim_off = (timer == FIM_OFF);
  assign ultimo  = (rom_endereco == rodada_reg);

  always_comb begin
    estado_prox = estado;
    case (estado)
      INICIAL: if (iniciar) estado_prox = BUSCA;
      BUSCA:   estado_prox = ACESO;
      ACESO:   if (fim_on) estado_prox = APAGADO;
      APAGADO: if (fim_off) estado_prox = ultimo ? FIM : BUSCA;
      FIM:     estado_prox = INICIAL;
      default: estado_prox = INICIAL;
    endcase
    if (zera) estado_prox = INICIAL;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado <= INICIAL;
    else          estado <= estado_prox;
  end

  // Address only moves on the APAGADO->BUSCA edge, so it is steady through ACESO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rodada_reg   <= '0;
      rom_endereco <= '0;
    end else if (zera) begin
      rom_endereco <= '0;
    end else if (estado == INICIAL && iniciar) begin
      rodada_reg   <= rodada;
      rom_endereco <= '0;
    end else if (estado == APAGADO && fim_off && !ultimo) begin
      rom_endereco <= rom_endereco + ADDR_W'(1);
    end
  end

  // Clearing on every state change means each phase starts counting from 0.
  assign zera_s = zera | (estado_prox != estado);
  assign conta  = (estado == ACESO) | (estado == APAGADO);

  contador_m #(
    .M (TMOD),
    .N (TW)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .zera_s  (zera_s),
    .conta   (conta),
    .q       (timer)
  );

  assign leds      = (estado == ACESO) ? rom_dado : '0;
  assign ocupado   = (estado != INICIAL);
  assign pronto    = (estado == FIM);
  assign db_estado = estado;

endmodule

// File: tb/tb_mostra_sequencia.sv
// Bench for mostra_sequencia with T_ON=4, T_OFF=2 and a synchronous ROM model.
module tb_mostra_sequencia;
  import jogo_pkg::*;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;
  localparam int PER   = 1 + T_ON + T_OFF;

  logic       clock, reset_n, zera, iniciar;
  logic [3:0] rodada, rom_dado, rom_endereco, leds;
  logic       ocupado, pronto;
  logic [2:0] db_estado;

  mostra_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .zera         (zera),
    .iniciar      (iniciar),
    .rodada       (rodada),
    .rom_dado     (rom_dado),
    .rom_endereco (rom_endereco),
    .leds         (leds),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [3:0] rom_val(input logic [3:0] a);
    case (a)
      4'd0: return 4'd1;   4'd1: return 4'd2;   4'd2: return 4'd4;   4'd3: return 4'd8;
      4'd4: return 4'd3;   4'd5: return 4'd5;   4'd6: return 4'd6;   4'd7: return 4'd9;
      4'd8: return 4'd10;  4'd9: return 4'd12;  4'd10: return 4'd7;  4'd11: return 4'd11;
      4'd12: return 4'd13; 4'd13: return 4'd14; 4'd14: return 4'd15; default: return 4'd6;
    endcase
  endfunction

  always @(posedge clock) rom_dado <= rom_val(rom_endereco);

  // scoreboard
  logic [3:0] exp_q[$];
  int         exp_pronto_q[$];
  logic [3:0] exp_addr_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every lit sample and every pronto pulse must match the queues
  always @(negedge clock) begin
    if (reset_n) begin
      if (leds !== 4'd0) begin
        if (exp_q.size() == 0) check("leds_extra", {28'd0, leds}, 32'd0);
        else                   check("leds", {28'd0, leds}, {28'd0, exp_q.pop_front()});
      end
      if (pronto !== 1'b0) begin
        if (exp_pronto_q.size() == 0) begin
          check("pronto_extra", {31'd0, pronto}, 32'd0);
        end else begin
          check("pronto_cycle", cyc, exp_pronto_q.pop_front());
          check("end_address", {28'd0, rom_endereco}, {28'd0, exp_addr_q.pop_front()});
        end
      end
    end
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic push_entries(input int n);
    for (int e = 0; e < n; e++)
      for (int t = 0; t < T_ON; t++) exp_q.push_back(rom_val(4'(e)));
  endtask

  task automatic start_run(input logic [3:0] r, input bit full, output int k);
    @(negedge clock);
    iniciar = 1'b1;
    rodada  = r;
    @(posedge clock);
    #1;
    iniciar = 1'b0;
    k = cyc;
    if (full) begin
      push_entries(int'(r) + 1);
      exp_pronto_q.push_back(k + (int'(r) + 1) * PER);
      exp_addr_q.push_back(r);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!ocupado) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
    repeat (4) @(negedge clock);
    check({name, "_leds_left"}, exp_q.size(), 32'd0);
    check({name, "_pronto_left"}, exp_pronto_q.size(), 32'd0);
  endtask

  task automatic check_idle(input string name);
    check({name, "_estado"}, {29'd0, db_estado}, {29'd0, INICIAL});
    check({name, "_leds"}, {28'd0, leds}, 32'd0);
    check({name, "_ocupado"}, {31'd0, ocupado}, 32'd0);
    check({name, "_pronto"}, {31'd0, pronto}, 32'd0);
  endtask

  initial begin
    int k;
    reset_n = 1'b0;
    zera    = 1'b0;
    iniciar = 1'b0;
    rodada  = 4'd0;
    repeat (2) @(negedge clock);
    check_idle("reset_held");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check_idle("reset");
    check("reset_addr", {28'd0, rom_endereco}, 32'd0);

    // single entry
    start_run(4'd0, 1'b1, k);
    check("single_ocupado", {31'd0, ocupado}, 32'd1);
    check("single_estado", {29'd0, db_estado}, {29'd0, BUSCA});
    wait_done("single", 50);

    // four entries
    start_run(4'd3, 1'b1, k);
    wait_done("four", 100);

    // full length, no address wrap
    start_run(4'd15, 1'b1, k);
    wait_done("full", 200);
    check("full_no_wrap", {28'd0, rom_endereco}, 32'd15);

    // abort during the second entry's lit phase
    start_run(4'd3, 1'b0, k);
    push_entries(1);
    exp_q.push_back(rom_val(4'd1));
    exp_q.push_back(rom_val(4'd1));
    wait_cyc(k + 1 + PER + 1);
    zera = 1'b1;
    @(negedge clock);
    zera = 1'b0;
    check_idle("abort");
    check("abort_addr", {28'd0, rom_endereco}, 32'd0);
    wait_done("abort", 10);
    start_run(4'd1, 1'b1, k);
    wait_done("restart", 50);

    // iniciar and rodada changes ignored while busy
    start_run(4'd1, 1'b1, k);
    wait_cyc(k + 3);
    iniciar = 1'b1;
    rodada  = 4'd7;
    @(negedge clock);
    iniciar = 1'b0;
    wait_done("ignored", 50);

    // zera wins over iniciar in INICIAL
    @(negedge clock);
    iniciar = 1'b1;
    zera    = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    zera    = 1'b0;
    check_idle("zera_priority");
    @(negedge clock);
    check_idle("zera_priority_hold");

    // asynchronous reset between edges mid-ACESO
    start_run(4'd0, 1'b1, k);
    wait_cyc(k + 2);
    #2;
    check("pre_reset_leds", {28'd0, leds}, {28'd0, rom_val(4'd0)});
    reset_n = 1'b0;
    #1;
    check("async_leds", {28'd0, leds}, 32'd0);
    check("async_ocupado", {31'd0, ocupado}, 32'd0);
    check("async_estado", {29'd0, db_estado}, 32'd0);
    exp_q.delete();
    exp_pronto_q.delete();
    exp_addr_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check_idle("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
